sele_arbiter: RTL and testbench
===============================

SELE_ARBITER -- requirements
Module: sele_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 8, legal range 1..255; the maximum number of consecutive cycles one requester may own the mux.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req  input  4  request vector; req[i]=1 means requester i wants mux input in[i].
REQ-005 Port: gnt  output  4  one-hot grant vector (or all-zero); registered.
REQ-006 Port: se1  output  1  mux select bit 1; registered.
REQ-007 Port: se2  output  1  mux select bit 2; registered.
REQ-008 Port: busy  output  1  high when gnt is non-zero.

Function
REQ-009 Select encoding SHALL be: index 0 -> se1=1,se2=1; index 1 -> se1=1,se2=0; index 2 -> se1=0,se2=1; index 3 -> se1=0,se2=0.
REQ-010 gnt SHALL be all-zero or exactly one-hot; never more than one bit set.
REQ-011 States SHALL be IDLE (no owner) and GRANT (owner index held in a 2-bit register).
REQ-012 Internal rotating pointer ptr (2 bits) SHALL define priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE -> GRANT: when req != 0, winner = first set req bit in priority order; gnt, se1/se2 and busy SHALL reflect the winner on the cycle after req is sampled (1-cycle latency).
REQ-014 IDLE with req == 0 SHALL stay IDLE; gnt=0, busy=0; se1/se2 SHALL hold the last owner's encoding.
REQ-015 In GRANT, hold counter cnt (8 bits) SHALL start at 0 on the first grant cycle and increment by 1 each cycle while the owner is unchanged.
REQ-016 Release condition: req[owner]==0 OR cnt==HOLD_MAX-1.
REQ-017 On release, ptr SHALL become owner+1 mod 4 (wrap 3 -> 0).
REQ-018 On release with any req bit set, the next cycle SHALL grant the new winner chosen with the updated ptr; there SHALL be no idle gap (back-to-back handoff), and cnt SHALL restart at 0.
REQ-019 On release with req == 0, the next state SHALL be IDLE and gnt SHALL be 0.
REQ-020 Timeout with only the owner still requesting SHALL re-grant the same owner with cnt restarting at 0; the owner is last in priority against any other requester.
REQ-021 A requester SHALL never be granted more than HOLD_MAX consecutive cycles while another req bit is set.
REQ-022 Starvation bound: a continuously asserted request SHALL be granted within 3*HOLD_MAX+1 cycles.
REQ-023 HOLD_MAX=1 SHALL release every cycle, giving pure per-cycle round-robin.
REQ-024 req bits that toggle mid-grant for non-owners SHALL have no effect until the next arbitration point.

Reset
REQ-025 While rst=1 at a clock edge, the next state SHALL be: state=IDLE, gnt=0000, busy=0, se1=1, se2=1 (index 0), ptr=0, cnt=0.
REQ-026 Reset asserted mid-grant SHALL drop the grant on the next edge regardless of req; the first arbitration after rst deasserts SHALL use ptr=0.

Verification
REQ-027 After reset, req=0001 -> next cycle gnt=0001, se1=1, se2=1, busy=1.
REQ-028 HOLD_MAX=4, req=1111 held -> gnt=0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001 again, with no zero cycles.
REQ-029 req=0100 for 2 cycles then 0000 -> gnt=0100 (se1=0,se2=1) for 2 cycles, then 0000; a later req=1111 -> gnt=1000 (ptr=3).
REQ-030 Owner 0 drops req in the same cycle req[2] is set -> next cycle gnt=0100, no gap, cnt=0.
REQ-031 rst pulsed during gnt=0010 with req=1111 -> gnt=0000 on the next edge; after release, gnt=0001.
REQ-032 HOLD_MAX=1, req=1010 -> gnt alternates 0010, 1000 every cycle; gnt is never 0000 and never has two bits set.

Source files
------------

// File: rtl/sele_arbiter.sv
// Four-way round-robin arbiter driving a 2-bit mux select; grant lags req by one cycle.
// No backpressure: an owner keeps the mux for at most HOLD_MAX cycles, then yields to the next requester.
module sele_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       se1,
  output logic       se2,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] gnt_nxt;
  logic       se1_nxt, se2_nxt;
  logic       rel;
  logic [1:0] base;
  logic [1:0] win;
  logic [1:0] idx;

  // Release uses the post-release pointer, so a lone timed-out owner is found last and re-granted.
  assign rel  = (state == GRANT) && (!req[owner] || (cnt == CNT_LAST));
  assign base = rel ? (owner + 2'd1) : ptr;
  assign busy = |gnt;

  // Scan from lowest priority to highest so the highest-priority hit is the final write.
  always_comb begin
    win = base;
    idx = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    se1_nxt   = se1;
    se2_nxt   = se2;
    case (state)
      IDLE: begin
        gnt_nxt = 4'b0000;
        if (|req) begin
          state_nxt = GRANT;
          owner_nxt = win;
          cnt_nxt   = 8'd0;
          gnt_nxt   = 4'b0001 << win;
          se1_nxt   = ~win[1];
          se2_nxt   = ~win[0];
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nxt = owner + 2'd1;
          cnt_nxt = 8'd0;
          if (|req) begin
            owner_nxt = win;
            gnt_nxt   = 4'b0001 << win;
            se1_nxt   = ~win[1];
            se2_nxt   = ~win[0];
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= 8'd0;
      gnt   <= 4'b0000;
      se1   <= 1'b1;
      se2   <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      se1   <= se1_nxt;
      se2   <= se2_nxt;
    end
  end

endmodule

// File: tb/tb_sele_arbiter.sv
// Directed bench for sele_arbiter: one instance with HOLD_MAX=4, one with HOLD_MAX=1.
module tb_sele_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req4 = 4'b0000;
  logic [3:0] req1 = 4'b0000;
  logic [3:0] gnt4, gnt1;
  logic       se1_4, se2_4, busy4;
  logic       se1_1, se2_1, busy1;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  sele_arbiter #(.HOLD_MAX(4)) u4 (
    .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .se1(se1_4), .se2(se2_4), .busy(busy4)
  );

  sele_arbiter #(.HOLD_MAX(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .se1(se1_1), .se2(se2_1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req4 = 4'b0000;
    req1 = 4'b0000;
    tick();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req4 = 4'b1111;
    req1 = 4'b1111;
    tick();
    tick();
    total++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_gnt4: gnt=%b busy=%b want gnt=0000 busy=0", gnt4, busy4);
    end
    total++;
    if (se1_4 !== 1'b1 || se2_4 !== 1'b1) begin
      bad++;
      $display("FAIL reset_sel4: se1=%b se2=%b want 1 1", se1_4, se2_4);
    end
    total++;
    if (gnt1 !== 4'b0000 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_gnt1: gnt=%b busy=%b want gnt=0000 busy=0", gnt1, busy1);
    end
    rst  = 1'b0;
    req4 = 4'b0000;
    req1 = 4'b0000;
    tick();
    total++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_req: gnt=%b busy=%b want 0000 0", gnt4, busy4);
    end
  endtask

  task automatic test_single();
    do_reset();
    req4 = 4'b0001;
    tick();
    total++;
    if (gnt4 !== 4'b0001 || se1_4 !== 1'b1 || se2_4 !== 1'b1 || busy4 !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: gnt=%b se=%b%b busy=%b want 0001 11 1", gnt4, se1_4, se2_4, busy4);
    end
    // Lone owner past its timeout keeps the grant with no gap.
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (gnt4 !== 4'b0001) begin
        bad++;
        $display("FAIL single_regrant[%0d]: gnt=%b want 0001", i, gnt4);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] exp_s [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    do_reset();
    req4 = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      tick();
      total++;
      if (gnt4 !== exp_g[(k / 4) % 4] || {se1_4, se2_4} !== exp_s[(k / 4) % 4]) begin
        bad++;
        $display("FAIL rotation[%0d]: gnt=%b se=%b%b want gnt=%b se=%b",
                 k, gnt4, se1_4, se2_4, exp_g[(k / 4) % 4], exp_s[(k / 4) % 4]);
      end
    end
  endtask

  task automatic test_release_idle();
    do_reset();
    req4 = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (gnt4 !== 4'b0100 || se1_4 !== 1'b0 || se2_4 !== 1'b1) begin
        bad++;
        $display("FAIL owner2_hold[%0d]: gnt=%b se=%b%b want 0100 01", i, gnt4, se1_4, se2_4);
      end
    end
    req4 = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (gnt4 !== 4'b0000 || busy4 !== 1'b0 || se1_4 !== 1'b0 || se2_4 !== 1'b1) begin
        bad++;
        $display("FAIL idle_after_release[%0d]: gnt=%b busy=%b se=%b%b want 0000 0 01",
                 i, gnt4, busy4, se1_4, se2_4);
      end
    end
    req4 = 4'b1111;
    tick();
    total++;
    if (gnt4 !== 4'b1000 || se1_4 !== 1'b0 || se2_4 !== 1'b0) begin
      bad++;
      $display("FAIL ptr3_grant: gnt=%b se=%b%b want 1000 00", gnt4, se1_4, se2_4);
    end
  endtask

  task automatic test_handoff();
    do_reset();
    req4 = 4'b0001;
    tick();
    total++;
    if (gnt4 !== 4'b0001) begin
      bad++;
      $display("FAIL handoff_first: gnt=%b want 0001", gnt4);
    end
    req4 = 4'b0100;
    tick();
    total++;
    if (gnt4 !== 4'b0100) begin
      bad++;
      $display("FAIL handoff_no_gap: gnt=%b want 0100", gnt4);
    end
    // A restarted hold count gives owner 2 four cycles before yielding to 1.
    req4 = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (gnt4 !== 4'b0100) begin
        bad++;
        $display("FAIL handoff_hold[%0d]: gnt=%b want 0100", i, gnt4);
      end
    end
    tick();
    total++;
    if (gnt4 !== 4'b0010) begin
      bad++;
      $display("FAIL handoff_yield: gnt=%b want 0010", gnt4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req4 = 4'b1111;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (gnt4 !== 4'b0010) begin
      bad++;
      $display("FAIL midreset_setup: gnt=%b want 0010", gnt4);
    end
    rst = 1'b1;
    tick();
    total++;
    if (gnt4 !== 4'b0000 || busy4 !== 1'b0 || se1_4 !== 1'b1 || se2_4 !== 1'b1) begin
      bad++;
      $display("FAIL midreset_drop: gnt=%b busy=%b se=%b%b want 0000 0 11", gnt4, busy4, se1_4, se2_4);
    end
    rst = 1'b0;
    tick();
    total++;
    if (gnt4 !== 4'b0001) begin
      bad++;
      $display("FAIL midreset_ptr0: gnt=%b want 0001", gnt4);
    end
  endtask

  task automatic test_hold1();
    logic [3:0] exp;
    do_reset();
    req1 = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      total++;
      if (gnt1 !== exp || busy1 !== 1'b1) begin
        bad++;
        $display("FAIL hold1_rr[%0d]: gnt=%b busy=%b want %b 1", i, gnt1, busy1, exp);
      end
    end
    total++;
    if ({se1_1, se2_1} !== 2'b00) begin
      bad++;
      $display("FAIL hold1_sel: se=%b%b want 00", se1_1, se2_1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_release_idle();
    test_handoff();
    test_reset_mid();
    test_hold1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
